// File: rtl/resize_axis_mul_pkg.sv
// Shared widths and helpers for the resize_axis weight-tap multiplier arbiter.
package resize_axis_mul_pkg;

    localparam int A_W = 20;  // signed pixel operand
    localparam int B_W = 8;   // unsigned weight operand
    localparam int P_W = 28;  // full-precision signed product

    // Smallest width w (at least 1) with 2**w >= n.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((32'sd1 <<< w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Signed-by-unsigned multiply. Both operands are extended to P_W bits and
    // the low P_W bits of the product are kept; the exact result always fits.
    function automatic logic signed [P_W-1:0] mul_ab(input logic [A_W-1:0] a,
                                                     input logic [B_W-1:0] b);
        logic [P_W-1:0] wa;
        logic [P_W-1:0] wb;
        wa = {{(P_W-A_W){a[A_W-1]}}, a};
        wb = {{(P_W-B_W){1'b0}}, b};
        return $signed(wa * wb);
    endfunction

endpackage

// File: rtl/resize_axis_mul_pipe.sv
// Registered multiplier. The operand register is the first stage and the
// consumer's result register (the FIFO entry) is the last one, so STAGES-1
// register levels live here. Valid bits are reset, data registers are not.
module resize_axis_mul_pipe
    import resize_axis_mul_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int ID_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [A_W-1:0]        in_a,
    input  logic [B_W-1:0]        in_b,
    input  logic [ID_W-1:0]       in_id,
    output logic                  out_valid,
    output logic signed [P_W-1:0] out_p,
    output logic [ID_W-1:0]       out_id
);

    generate
        if (STAGES == 1) begin : g_comb
            assign out_valid = in_valid;
            assign out_p     = mul_ab(in_a, in_b);
            assign out_id    = in_id;
        end else begin : g_reg
            logic                  v0_r;
            logic [A_W-1:0]        a0_r;
            logic [B_W-1:0]        b0_r;
            logic [ID_W-1:0]       id0_r;
            logic signed [P_W-1:0] prod_s;

            // Operand stage valid bit; cleared so reset discards in-flight work.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v0_r <= 1'b0;
                end else begin
                    v0_r <= in_valid;
                end
            end

            // Operand stage data, captured every cycle without reset.
            always_ff @(posedge clk) begin
                a0_r  <= in_a;
                b0_r  <= in_b;
                id0_r <= in_id;
            end

            assign prod_s = mul_ab(a0_r, b0_r);

            if (STAGES == 2) begin : g_direct
                assign out_valid = v0_r;
                assign out_p     = prod_s;
                assign out_id    = id0_r;
            end else begin : g_shift
                logic                  v_r  [STAGES-2];
                logic signed [P_W-1:0] p_r  [STAGES-2];
                logic [ID_W-1:0]       id_r [STAGES-2];

                // Product-stage valid shift register.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int i = 0; i < STAGES-2; i++) begin
                            v_r[i] <= 1'b0;
                        end
                    end else begin
                        v_r[0] <= v0_r;
                        for (int i = 1; i < STAGES-2; i++) begin
                            v_r[i] <= v_r[i-1];
                        end
                    end
                end

                // Product-stage data shift register.
                always_ff @(posedge clk) begin
                    p_r[0]  <= prod_s;
                    id_r[0] <= id0_r;
                    for (int i = 1; i < STAGES-2; i++) begin
                        p_r[i]  <= p_r[i-1];
                        id_r[i] <= id_r[i-1];
                    end
                end

                assign out_valid = v_r[STAGES-3];
                assign out_p     = p_r[STAGES-3];
                assign out_id    = id_r[STAGES-3];
            end
        end
    endgenerate

endmodule

// File: rtl/resize_axis_mul_arbiter.sv
// Round-robin scheduler sharing one multiplier among NREQ bilinear weight taps.
// Issue is credit-gated so the result FIFO can never overflow.
module resize_axis_mul_arbiter
    import resize_axis_mul_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int MUL_STAGES = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*A_W-1:0]      req_a,
    input  logic [NREQ*B_W-1:0]      req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [P_W-1:0]    res_p,
    output logic [clog2(NREQ)-1:0]   res_id,
    output logic                     busy
);

    localparam int ID_W  = clog2(NREQ);
    localparam int FP_W  = clog2(FIFO_DEPTH);
    localparam int CNT_W = clog2(FIFO_DEPTH + MUL_STAGES + 1);

    logic [ID_W-1:0]       ptr_r;
    logic [ID_W-1:0]       grant_idx_s;
    logic                  grant_any_s;
    logic [CNT_W-1:0]      in_flight_r;
    logic [CNT_W-1:0]      fifo_count_r;
    logic [CNT_W-1:0]      outstanding_s;
    logic                  can_issue_s;
    logic                  issue_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  pipe_valid_s;
    logic signed [P_W-1:0] pipe_p_s;
    logic [ID_W-1:0]       pipe_id_s;
    logic signed [P_W-1:0] mem_p_r  [FIFO_DEPTH];
    logic [ID_W-1:0]       mem_id_r [FIFO_DEPTH];
    logic [FP_W-1:0]       wr_ptr_r;
    logic [FP_W-1:0]       rd_ptr_r;
    logic signed [P_W-1:0] last_p_r;
    logic [ID_W-1:0]       last_id_r;

    assign outstanding_s = in_flight_r + fifo_count_r;
    assign can_issue_s   = (outstanding_s < CNT_W'(FIFO_DEPTH));
    assign issue_s       = |(req_valid & req_ready);
    assign push_s        = pipe_valid_s;
    assign res_valid     = (fifo_count_r != {CNT_W{1'b0}});
    assign pop_s         = res_valid & res_ready;
    assign busy          = (outstanding_s != {CNT_W{1'b0}});
    assign res_p         = res_valid ? mem_p_r[rd_ptr_r]  : last_p_r;
    assign res_id        = res_valid ? mem_id_r[rd_ptr_r] : last_id_r;

    // Cyclic search from ptr for the first valid requester.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = {ID_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any_s && req_valid[(int'(ptr_r) + k) % NREQ]) begin
                grant_any_s = 1'b1;
                grant_idx_s = ID_W'((int'(ptr_r) + k) % NREQ);
            end else begin
                grant_any_s = grant_any_s;
            end
        end
    end

    // One-hot ready for the winner, suppressed when out of credit or in reset.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (grant_any_s && can_issue_s && ap_rst_n) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    resize_axis_mul_pipe #(
        .STAGES (MUL_STAGES),
        .ID_W   (ID_W)
    ) u_pipe (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .in_valid  (issue_s),
        .in_a      (req_a[int'(grant_idx_s)*A_W +: A_W]),
        .in_b      (req_b[int'(grant_idx_s)*B_W +: B_W]),
        .in_id     (grant_idx_s),
        .out_valid (pipe_valid_s),
        .out_p     (pipe_p_s),
        .out_id    (pipe_id_s)
    );

    // Round-robin pointer and credit counters; a pop frees credit one cycle later.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_r        <= {ID_W{1'b0}};
            in_flight_r  <= {CNT_W{1'b0}};
            fifo_count_r <= {CNT_W{1'b0}};
        end else begin
            if (issue_s) begin
                ptr_r <= (grant_idx_s == ID_W'(NREQ-1)) ? {ID_W{1'b0}} : grant_idx_s + ID_W'(1);
            end else begin
                ptr_r <= ptr_r;
            end
            in_flight_r  <= in_flight_r + CNT_W'(issue_s) - CNT_W'(push_s);
            fifo_count_r <= fifo_count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Result FIFO storage, pointers and the last-popped value shown while empty.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_r  <= {FP_W{1'b0}};
            rd_ptr_r  <= {FP_W{1'b0}};
            last_p_r  <= {P_W{1'b0}};
            last_id_r <= {ID_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_p_r[i]  <= {P_W{1'b0}};
                mem_id_r[i] <= {ID_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                mem_p_r[wr_ptr_r]  <= pipe_p_s;
                mem_id_r[wr_ptr_r] <= pipe_id_s;
                wr_ptr_r <= (wr_ptr_r == FP_W'(FIFO_DEPTH-1)) ? {FP_W{1'b0}} : wr_ptr_r + FP_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                last_p_r  <= mem_p_r[rd_ptr_r];
                last_id_r <= mem_id_r[rd_ptr_r];
                rd_ptr_r  <= (rd_ptr_r == FP_W'(FIFO_DEPTH-1)) ? {FP_W{1'b0}} : rd_ptr_r + FP_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

endmodule
